mem_rd_ctrl: RTL and testbench

Memory-mapped read-side peripheral for the CPU data bus: the load counterpart of the store-only output controller. External 16-bit input samples are buffered in a small FIFO; the CPU pops them with loads from a data address and polls a status word at a second address. Sits beside the store controller on the same `addr` bus, with a registered one-cycle read response.

---
 rtl/mem_rd_ctrl.sv | 102 ++++++++++
 tb/tb_mem_rd_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_rd_ctrl.sv
// Read-side memory-mapped peripheral: buffers 16-bit external samples in a FIFO
// that the CPU pops through DATA_ADDR and inspects through STAT_ADDR.
module mem_rd_ctrl #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] DATA_ADDR = 32'h24,
    parameter logic [31:0] STAT_ADDR = 32'h28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;

    logic       empty, full, push, drop, data_rd, stat_rd, pop;
    logic [7:0] count8;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign push    = in_valid & ~full;
    assign drop    = in_valid & full;
    assign data_rd = re & (addr == DATA_ADDR);
    assign stat_rd = re & (addr == STAT_ADDR);
    assign pop     = data_rd & ~empty;
    assign count8  = 8'(count_q);

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path can infer a latch.
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        rdata_d  = rdata_q;
        rvalid_d = re;

        if (re) begin
            rdata_d = 32'h0;
            if (pop)
                rdata_d = {16'h0, mem_q[rptr_q]};
            else if (stat_rd)
                rdata_d = {16'h0, count8, 4'h0, 1'b0, ovf_q, full, empty};
        end

        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a status read must survive the clear.
        if (drop)
            ovf_d = 1'b1;
        else if (stat_rd)
            ovf_d = 1'b0;
    end

    // NOTE: the sample array has no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign in_ready = ~full;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_mem_rd_ctrl.sv
// Directed self-checking bench for mem_rd_ctrl with DEPTH=8.
module tb_mem_rd_ctrl;
    localparam logic [31:0] DA = 32'h24;
    localparam logic [31:0] SA = 32'h28;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        re;
    logic [31:0] rdata;
    logic        rvalid;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        overflow;

    int passed = 0;
    int total  = 0;

    mem_rd_ctrl #(.DEPTH(8), .DATA_ADDR(DA), .STAT_ADDR(SA)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .re       (re),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
    task automatic step(input logic r, input logic [31:0] a, input logic v, input logic [15:0] d);
        @(negedge clk);
        re = r; addr = a; in_valid = v; in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        step(1'b1, a, 1'b0, 16'h0);
        check(tag, rdata, exp);
        check({tag, "_rvalid"}, 32'(rvalid), 32'h1);
    endtask

    task automatic push(input logic [15:0] d);
        step(1'b0, 32'h0, 1'b1, d);
    endtask

    initial begin
        rst_n = 1'b0; re = 1'b0; addr = 32'h0; in_valid = 1'b0; in_data = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata",    rdata,            32'h0);
        check("rst_rvalid",   32'(rvalid),      32'h0);
        check("rst_in_ready", 32'(in_ready),    32'h1);
        check("rst_overflow", 32'(overflow),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        rd(SA, 32'h0000_0001, "stat_after_reset");

        // Basic ordering and empty read.
        push(16'h1111);
        check("idle_rvalid", 32'(rvalid), 32'h0);
        check("idle_hold",   rdata,       32'h0000_0001);
        push(16'h2222);
        push(16'h3333);
        rd(DA, 32'h0000_1111, "pop_1111");
        rd(DA, 32'h0000_2222, "pop_2222");
        rd(DA, 32'h0000_3333, "pop_3333");
        rd(DA, 32'h0000_0000, "pop_empty");
        rd(SA, 32'h0000_0001, "stat_empty");
        rd(32'h30, 32'h0000_0000, "bad_addr");

        // Fill, overflow, sticky clear.
        for (int i = 1; i <= 8; i++) begin
            push(16'(i));
            if (i == 7) check("in_ready_7", 32'(in_ready), 32'h1);
        end
        check("in_ready_full", 32'(in_ready), 32'h0);
        check("ovf_before",    32'(overflow), 32'h0);
        push(16'h0009);
        check("ovf_set", 32'(overflow), 32'h1);
        rd(SA, 32'h0000_0806, "stat_full_ovf");
        check("ovf_cleared", 32'(overflow), 32'h0);
        rd(SA, 32'h0000_0802, "stat_full");
        rd(DA, 32'h0000_0001, "drain_1");
        check("in_ready_unfull", 32'(in_ready), 32'h1);
        for (int i = 2; i <= 8; i++) rd(DA, 32'(i), $sformatf("drain_%0d", i));
        rd(DA, 32'h0, "drain_empty");

        // Pointer wrap-around.
        for (int i = 0; i < 6; i++) push(16'hA000 + 16'(i));
        for (int i = 0; i < 6; i++) rd(DA, 32'hA000 + 32'(i), $sformatf("wrap_a%0d", i));
        for (int i = 0; i < 8; i++) push(16'hB000 + 16'(i));
        for (int i = 0; i < 8; i++) rd(DA, 32'hB000 + 32'(i), $sformatf("wrap_b%0d", i));
        rd(SA, 32'h0000_0001, "stat_wrap_end");

        // Simultaneous push and pop.
        push(16'hC001); push(16'hC002); push(16'hC003);
        step(1'b1, DA, 1'b1, 16'hC004);
        check("pp3_rdata", rdata, 32'h0000_C001);
        rd(SA, 32'h0000_0300, "pp3_stat");
        rd(DA, 32'h0000_C002, "pp3_c2");
        rd(DA, 32'h0000_C003, "pp3_c3");
        rd(DA, 32'h0000_C004, "pp3_c4");
        step(1'b1, DA, 1'b1, 16'hD001);
        check("pp0_rdata",  rdata,       32'h0);
        check("pp0_rvalid", 32'(rvalid), 32'h1);
        rd(SA, 32'h0000_0100, "pp0_stat");
        rd(DA, 32'h0000_D001, "pp0_d1");

        // Drop coinciding with a status read keeps overflow set.
        for (int i = 0; i < 8; i++) push(16'hE000 + 16'(i));
        step(1'b1, SA, 1'b1, 16'hEEEE);
        check("ovf_race_stat", rdata, 32'h0000_0802);
        check("ovf_race_flag", 32'(overflow), 32'h1);
        for (int i = 0; i < 3; i++) rd(DA, 32'hE000 + 32'(i), $sformatf("pre_rst_%0d", i));

        // Reset mid-operation with a pending read and count=5.
        @(negedge clk);
        re = 1'b1; addr = DA; in_valid = 1'b0; rst_n = 1'b0;
        #1;
        check("rst_mid_rvalid_async", 32'(rvalid), 32'h0);
        @(posedge clk);
        #1;
        check("rst_mid_rvalid", 32'(rvalid),   32'h0);
        check("rst_mid_rdata",  rdata,         32'h0);
        check("rst_mid_ovf",    32'(overflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; re = 1'b0;
        check("rst_mid_ready", 32'(in_ready), 32'h1);
        rd(SA, 32'h0000_0001, "stat_after_mid_rst");
        step(1'b0, 32'h0, 1'b0, 16'h0);
        check("final_rvalid", 32'(rvalid), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
